// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction descriptors over a valid/ready handshake,
// encodes each legal one into a 32-bit machine word and writes it into
// instruction memory at a sequential word address. The load stops on the
// Last descriptor, when memory is filled, or on an illegal mnemonic that is
// also marked Last.
module instr_encoder #(
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [3:0]         Mnemonic,
  input  logic [4:0]         Rs,
  input  logic [4:0]         Rt,
  input  logic [4:0]         Rd,
  input  logic [15:0]        Imm,
  input  logic               Last,
  output logic               ImemWE,
  output logic [IMEM_AW-1:0] ImemAddr,
  output logic [31:0]        ImemWD,
  output logic [IMEM_AW:0]   Count,
  output logic               Done,
  output logic               Full,
  output logic               Error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [IMEM_AW-1:0] PTR_ONE   = {{(IMEM_AW-1){1'b0}}, 1'b1};
  localparam logic [IMEM_AW-1:0] PTR_MAX   = {IMEM_AW{1'b1}};
  localparam logic [IMEM_AW:0]   COUNT_ONE = {{IMEM_AW{1'b0}}, 1'b1};

  state_t             state_r;
  logic [IMEM_AW-1:0] ptr_r;
  logic [IMEM_AW:0]   count_r;
  logic               last_r;
  logic               ready_r;
  logic               we_r;
  logic [31:0]        wd_r;
  logic               done_r;
  logic               full_r;
  logic               error_r;
  logic               xfer_s;

  // Mnemonics 0..10 are defined; 11..15 are rejected.
  function automatic logic isLegal(input logic [3:0] mnem);
    isLegal = (mnem <= 4'd10);
  endfunction

  // Builds the machine word. Only the fields a format actually uses are
  // placed, so stray Rd/Imm (R-type) or Rd (I-type) cannot leak in.
  function automatic logic [31:0] encodeWord(
    input logic [3:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    logic [31:0] word;
    word = 32'h0000_0000;
    case (mnem)
      4'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000}; // ADD
      4'd1:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010}; // SUB
      4'd2:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100}; // AND
      4'd3:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101}; // OR
      4'd4:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b000000}; // ANN
      4'd5:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b111111}; // WGHT
      4'd6:    word = {6'b100011, rs, rt, imm};                     // LW
      4'd7:    word = {6'b101011, rs, rt, imm};                     // SW
      4'd8:    word = {6'b000100, rs, 5'b00000, imm};               // BEQZ
      4'd9:    word = {6'b001000, rs, rt, imm};                     // ADDI
      4'd10:   word = {6'b001001, rs, rt, imm};                     // SUBI
      default: word = 32'h0000_0000;
    endcase
    encodeWord = word;
  endfunction

  // A transfer needs the encoder to be in IDLE, which is what ready_r tracks.
  assign xfer_s = InValid & ready_r;

  // Load FSM: captures the encoded descriptor on transfer, strobes it for one
  // cycle, then advances pointer/count and decides whether loading continues.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= {IMEM_AW{1'b0}};
      count_r <= {(IMEM_AW+1){1'b0}};
      last_r  <= 1'b0;
      ready_r <= 1'b1;
      we_r    <= 1'b0;
      wd_r    <= 32'h0000_0000;
      done_r  <= 1'b0;
      full_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            if (isLegal(Mnemonic)) begin
              // Strobe goes high in the cycle right after the transfer edge.
              state_r <= WRITE;
              ready_r <= 1'b0;
              we_r    <= 1'b1;
              wd_r    <= encodeWord(Mnemonic, Rs, Rt, Rd, Imm);
              last_r  <= Last;
            end else begin
              // Illegal: no write, pointer and count untouched.
              error_r <= 1'b1;
              if (Last) begin
                state_r <= DONE;
                ready_r <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                state_r <= IDLE;
                ready_r <= 1'b1;
              end
            end
          end else begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end
        end
        WRITE: begin
          we_r    <= 1'b0;
          wd_r    <= 32'h0000_0000;
          count_r <= count_r + COUNT_ONE;
          if (ptr_r == PTR_MAX) begin
            // Top word written: pointer holds instead of wrapping.
            full_r  <= full_r | ~last_r;
            state_r <= DONE;
            ready_r <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            ptr_r <= ptr_r + PTR_ONE;
            if (last_r) begin
              state_r <= DONE;
              ready_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              ready_r <= 1'b1;
            end
          end
        end
        DONE: begin
          // Terminal until reset.
          state_r <= DONE;
          ready_r <= 1'b0;
          we_r    <= 1'b0;
          wd_r    <= 32'h0000_0000;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          we_r    <= 1'b0;
          wd_r    <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign InReady  = ready_r;
  assign ImemWE   = we_r;
  assign ImemWD   = wd_r;
  assign ImemAddr = ptr_r;
  assign Count    = count_r;
  assign Done     = done_r;
  assign Full     = full_r;
  assign Error    = error_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected (address, word) pairs are
// queued when a descriptor is driven and compared when ImemWE fires.
module tb_instr_encoder;

  localparam int IMEM_AW = 8;

  logic               clk;
  logic               reset;
  logic               InValid;
  logic               InReady;
  logic [3:0]         Mnemonic;
  logic [4:0]         Rs;
  logic [4:0]         Rt;
  logic [4:0]         Rd;
  logic [15:0]        Imm;
  logic               Last;
  logic               ImemWE;
  logic [IMEM_AW-1:0] ImemAddr;
  logic [31:0]        ImemWD;
  logic [IMEM_AW:0]   Count;
  logic               Done;
  logic               Full;
  logic               Error;

  int          errCount;
  int          checkCount;
  int          modelPtr;
  logic        monOn;
  logic [31:0] expAddr[$];
  logic [31:0] expWord[$];

  instr_encoder #(.IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .Mnemonic(Mnemonic), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm), .Last(Last),
    .ImemWE(ImemWE), .ImemAddr(ImemAddr), .ImemWD(ImemWD), .Count(Count),
    .Done(Done), .Full(Full), .Error(Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder built from field shifts.
  function automatic logic [31:0] refEncode(input int mn, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
    logic [31:0] w;
    logic [5:0]  f;
    logic [5:0]  op;
    w = 32'd0;
    f = 6'd0;
    op = 6'd0;
    if (mn <= 5) begin
      case (mn)
        0: f = 6'h20;
        1: f = 6'h22;
        2: f = 6'h24;
        3: f = 6'h25;
        4: f = 6'h00;
        default: f = 6'h3F;
      endcase
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(f);
    end else if (mn == 8) begin
      w = (32'd4 << 26) | (32'(rs) << 21) | 32'(imm);
    end else begin
      case (mn)
        6: op = 6'h23;
        7: op = 6'h2B;
        9: op = 6'h08;
        default: op = 6'h09;
      endcase
      w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    end
    return w;
  endfunction

  // Monitor: every strobe must match the head of the scoreboard; idle WD is 0.
  always @(negedge clk) begin
    if (monOn) begin
      if (ImemWE === 1'b1) begin
        if (expWord.size() == 0) begin
          checkVal("unexpected_write", 32'(ImemAddr), 32'hFFFF_FFFF);
        end else begin
          checkVal("write_addr", 32'(ImemAddr), expAddr.pop_front());
          checkVal("write_word", ImemWD, expWord.pop_front());
        end
      end else begin
        checkVal("wd_zero_when_idle", ImemWD, 32'd0);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    InValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelPtr = 0;
  endtask

  // Drive one descriptor; expW is the word the bench expects for a legal one.
  task automatic send(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic last, input logic [31:0] expW);
    int n;
    n = 0;
    @(negedge clk);
    while (InReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (InReady !== 1'b1) begin
      checkVal("ready_timeout", 32'(InReady), 32'd1);
    end else begin
      InValid = 1'b1; Mnemonic = mn; Rs = rs; Rt = rt; Rd = rd; Imm = imm; Last = last;
      if (mn <= 4'd10) begin
        expAddr.push_back(32'(modelPtr));
        expWord.push_back(expW);
        if (modelPtr < 255) modelPtr++;
      end
      @(posedge clk);
      #1;
      InValid = 1'b0;
    end
  endtask

  task automatic sendRand(input logic last);
    logic [3:0]  mn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    mn  = 4'($urandom_range(0, 10));
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    send(mn, rs, rt, rd, imm, last, refEncode(int'(mn), rs, rt, rd, imm));
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkVal("done_reached", 32'(Done), 32'd1);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (expWord.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkVal(tag, 32'(expWord.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    errCount = 0; checkCount = 0; modelPtr = 0; monOn = 1'b0;
    reset = 1'b1; InValid = 1'b0; Mnemonic = 4'd0; Rs = 5'd0; Rt = 5'd0;
    Rd = 5'd0; Imm = 16'd0; Last = 1'b0;
    doReset();
    monOn = 1'b1;

    // Reset state.
    checkVal("rst_ready", 32'(InReady), 32'd1);
    checkVal("rst_we", 32'(ImemWE), 32'd0);
    checkVal("rst_addr", 32'(ImemAddr), 32'd0);
    checkVal("rst_count", 32'(Count), 32'd0);
    checkVal("rst_flags", {29'd0, Done, Full, Error}, 32'd0);

    // ADD 1,2,3 with junk Imm (must not affect the word).
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 1'b0, 32'h0022_1820);
    checkVal("add_we_latency", 32'(ImemWE), 32'd1);
    @(posedge clk); #1;
    checkVal("add_count", 32'(Count), 32'd1);
    checkVal("add_ready_again", 32'(InReady), 32'd1);
    waitDrain("add_drain");

    // LW then SUBI Last=1.
    doReset();
    send(4'd6, 5'd4, 5'd5, 5'd17, 16'h0010, 1'b0, 32'h8C85_0010);
    send(4'd10, 5'd5, 5'd6, 5'd9, 16'hFFFF, 1'b1, 32'h24A6_FFFF);
    waitDone();
    checkVal("lw_subi_count", 32'(Count), 32'd2);
    checkVal("lw_subi_ready", 32'(InReady), 32'd0);
    // DONE is terminal: offered descriptors are ignored.
    Mnemonic = 4'd0; Last = 1'b0; InValid = 1'b1;
    repeat (4) @(negedge clk);
    InValid = 1'b0;
    checkVal("done_sticky", 32'(Done), 32'd1);
    checkVal("done_count_hold", 32'(Count), 32'd2);
    waitDrain("lw_subi_drain");

    // BEQZ with Rt and Rd ignored.
    doReset();
    send(4'd8, 5'd7, 5'd9, 5'd31, 16'h0003, 1'b0, 32'h10E0_0003);
    waitDrain("beqz_drain");

    // Illegal mnemonic Last=0, then OR at address 0.
    doReset();
    send(4'd12, 5'd3, 5'd3, 5'd3, 16'h1234, 1'b0, 32'd0);
    checkVal("ill_error", 32'(Error), 32'd1);
    checkVal("ill_count", 32'(Count), 32'd0);
    checkVal("ill_ready", 32'(InReady), 32'd1);
    checkVal("ill_addr", 32'(ImemAddr), 32'd0);
    send(4'd3, 5'd1, 5'd1, 5'd2, 16'h0000, 1'b0, 32'h0021_1025);
    waitDrain("or_drain");
    checkVal("ill_error_sticky", 32'(Error), 32'd1);

    // Illegal with Last=1 ends the load without a write.
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 32'd0);
    waitDone();
    checkVal("ill_last_count", 32'(Count), 32'd1);
    checkVal("ill_last_ready", 32'(InReady), 32'd0);

    // Random legal descriptors.
    doReset();
    for (int i = 0; i < 12; i++) sendRand(1'b0);
    waitDrain("rand_drain");
    checkVal("rand_count", 32'(Count), 32'd12);

    // Fill all 256 words without Last.
    doReset();
    for (int i = 0; i < 256; i++) sendRand(1'b0);
    waitDone();
    waitDrain("fill_drain");
    checkVal("fill_full", 32'(Full), 32'd1);
    checkVal("fill_count", 32'(Count), 32'd256);
    checkVal("fill_ready", 32'(InReady), 32'd0);
    checkVal("fill_addr_hold", 32'(ImemAddr), 32'hFF);

    // Reset in the WRITE cycle of the third instruction.
    doReset();
    sendRand(1'b0);
    sendRand(1'b0);
    sendRand(1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelPtr = 0;
    checkVal("rw_we", 32'(ImemWE), 32'd0);
    checkVal("rw_count", 32'(Count), 32'd0);
    checkVal("rw_flags", {29'd0, Done, Full, Error}, 32'd0);
    waitDrain("rw_drain_inflight");
    send(4'd9, 5'd2, 5'd3, 5'd4, 16'h00FF, 1'b0, 32'h2043_00FF);
    waitDrain("rw_drain_after");
    checkVal("rw_count_after", 32'(Count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have the following parameter: IMEM_AW, 8, word-address width of instruction memory (256 words).
REQ-002 The block SHALL have the following ports, one per line:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- InValid  in  1  source presents an instruction descriptor
- InReady  out  1  encoder can accept a descriptor this cycle
- Mnemonic  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ANN, 5 WGHT, 6 LW, 7 SW, 8 BEQZ, 9 ADDI, 10 SUBI; 11-15 illegal
- Rs  in  5  source register
- Rt  in  5  second source / I-type destination
- Rd  in  5  R-type destination
- Imm  in  16  immediate / offset
- Last  in  1  descriptor is final instruction of program
- ImemWE  out  1  instruction-memory write strobe
- ImemAddr  out  IMEM_AW  word address being written
- ImemWD  out  32  encoded instruction word
- Count  out  IMEM_AW+1  number of words written
- Done  out  1  program load complete (sticky)
- Full  out  1  memory filled before Last (sticky)
- Error  out  1  illegal mnemonic received (sticky)

Function
REQ-003 Transfer SHALL occur on a rising edge where InValid and InReady are both 1; the descriptor fields SHALL be registered on that edge.
REQ-004 FSM states SHALL be IDLE, WRITE, DONE; InReady SHALL be 1 only in IDLE.
REQ-005 IDLE -> WRITE on a transfer with a legal mnemonic; IDLE -> DONE on a transfer with an illegal mnemonic and Last=1; otherwise remain IDLE.
REQ-006 In WRITE, ImemWE SHALL be 1 for exactly one cycle with ImemWD = encoded word and ImemAddr = current write pointer; latency transfer-edge to ImemWE high = 1 cycle; throughput = 1 word per 2 cycles.
REQ-007 At the end of WRITE the pointer SHALL increment by 1 and Count SHALL increment by 1; next state DONE if registered Last=1 or pointer was 2^IMEM_AW-1, else IDLE.
REQ-008 Writing pointer 2^IMEM_AW-1 with Last=0 SHALL set Full; the pointer SHALL NOT wrap to 0.
REQ-009 Illegal mnemonic SHALL set Error, produce no write, leave pointer and Count unchanged.
REQ-010 DONE SHALL be terminal until reset: Done=1, InReady=0, ImemWE=0.
REQ-011 R-type (0-5) word SHALL be {6'b000000, Rs, Rt, Rd, 5'b00000, funct}, funct: ADD 100000, SUB 100010, AND 100100, OR 100101, ANN 000000, WGHT 111111.
REQ-012 I-type word SHALL be {op, Rs, Rt, Imm}, op: LW 100011, SW 101011, ADDI 001000, SUBI 001001.
REQ-013 BEQZ word SHALL be {6'b000100, Rs, 5'b00000, Imm}; Rt and Rd SHALL be ignored.
REQ-014 Fields unused by a format (Rd, Imm for R-type; Rd for I-type) SHALL NOT affect ImemWD.
REQ-015 ImemWD SHALL be 0 whenever ImemWE is 0.

Reset
REQ-016 reset=1 at a rising edge SHALL force state IDLE, pointer 0, Count 0, Done 0, Full 0, Error 0, ImemWE 0, ImemWD 0, ImemAddr 0; InReady 1 from the following cycle.
REQ-017 reset asserted during WRITE SHALL suppress ImemWE from the next cycle; the in-flight word is discarded and pointer returns to 0.
REQ-018 reset SHALL take priority over a simultaneous transfer; the descriptor is not accepted.

Verification
REQ-019 ADD Rs=1 Rt=2 Rd=3 Last=0 -> next cycle ImemWE=1, ImemAddr=0, ImemWD=0x00221820; Count=1 after.
REQ-020 LW Rs=4 Rt=5 Imm=0x0010 then SUBI Rs=5 Rt=6 Imm=0xFFFF Last=1 -> words 0x8C850010 @0, 0x24A6FFFF @1; Done=1, Count=2, InReady=0.
REQ-021 BEQZ Rs=7 Rt=9 Imm=0x0003 -> ImemWD=0x10E00003 (Rt ignored).
REQ-022 Mnemonic=12, Last=0 -> Error=1, no ImemWE, Count unchanged, InReady stays 1; subsequent OR Rs=1 Rt=1 Rd=2 written at address 0 as 0x00211025.
REQ-023 256 legal descriptors with Last=0 -> last write at 0xFF, Full=1, Done=1, Count=256, InReady=0.
REQ-024 reset asserted in WRITE cycle of third instruction -> ImemWE=0 next cycle, Count=0, Done/Full/Error=0, next write at address 0.
